// File: rtl/clk_ctrl_regs.sv
// ----------------------------------------------------------------------------
// clk_ctrl_regs
//
// Control/status register bank on the internal register bus, directly behind
// the SPI register-access block. Bus writes land in shadow registers. The
// 32-bit clock divider moves from shadow to active in a single clock edge.
// That transfer happens either right away (IMMEDIATE) or at the next external
// sync pulse (ARM). The clock-generation logic therefore never sees a
// half-written divider.
//
// Register map (offset from BASE_ADDR):
//   0 ID      RO  ID_VALUE
//   1 CTRL    RW  bit0 -> o_enable
//   2..5 DIV  RW  shadow divider bytes, little-endian (offset 2 = bits 7:0)
//   6 CMD     WO  bit0 ARM, bit1 IMMEDIATE, bit2 ABORT, bit3 SOFT_RST (reads 0)
//   7 STATUS  RO  bit0 armed, bit1 done (sticky, cleared by any CMD write)
//
// Bus handshake: i_wr_enable_bus is a level. Exactly one write is taken on the
// rising edge of clk where it is 1 and was 0 on the previous edge. Holding it
// high never repeats the write. There is no ready/back-pressure; every edge
// detected write is accepted. o_data_read_bus is registered: it shows the
// register addressed at edge N, with contents as they were before any write on
// that same edge, and it is valid after edge N.
//
// Ports:
//   i_clk             system clock
//   i_rst             synchronous active-low reset
//   i_addr_bus        register address
//   i_data_write_bus  write data (low 8 bits are used)
//   i_wr_enable_bus   write request level
//   o_data_read_bus   registered read data
//   i_sync            one-cycle sync pulse from timing logic
//   o_enable          CTRL[0]
//   o_div             active divider
//   o_update          one-cycle pulse when o_div is reloaded
//   o_soft_rst        one-cycle soft-reset pulse for downstream logic
//   o_armed           high while the commit FSM waits for i_sync
// ----------------------------------------------------------------------------
module clk_ctrl_regs #(
    parameter int                    ADDR_WIDTH = 7,
    parameter int                    DATA_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 7'h00,
    parameter logic [7:0]            ID_VALUE   = 8'hC5,
    parameter logic [31:0]           DIV_RESET  = 32'd1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [ADDR_WIDTH-1:0] i_addr_bus,
    input  logic [DATA_WIDTH-1:0] i_data_write_bus,
    input  logic                  i_wr_enable_bus,
    output logic [DATA_WIDTH-1:0] o_data_read_bus,
    input  logic                  i_sync,
    output logic                  o_enable,
    output logic [31:0]           o_div,
    output logic                  o_update,
    output logic                  o_soft_rst,
    output logic                  o_armed
);

    // Register offsets inside the bank
    localparam logic [2:0] OFF_ID     = 3'd0;
    localparam logic [2:0] OFF_CTRL   = 3'd1;
    localparam logic [2:0] OFF_DIV0   = 3'd2;
    localparam logic [2:0] OFF_DIV1   = 3'd3;
    localparam logic [2:0] OFF_DIV2   = 3'd4;
    localparam logic [2:0] OFF_DIV3   = 3'd5;
    localparam logic [2:0] OFF_CMD    = 3'd6;
    localparam logic [2:0] OFF_STATUS = 3'd7;

    // CMD register bit positions
    localparam int CMD_ARM      = 0;
    localparam int CMD_IMM      = 1;
    localparam int CMD_ABORT    = 2;
    localparam int CMD_SOFT_RST = 3;

    // Commit state machine
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_APPLY = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Flops
    logic                  wr_en_q,    wr_en_d;
    logic [7:0]            ctrl_q,     ctrl_d;
    logic [31:0]           shadow_q,   shadow_d;
    logic [31:0]           div_q,      div_d;
    logic                  done_q,     done_d;
    logic                  update_q,   update_d;
    logic                  soft_rst_q, soft_rst_d;
    logic [DATA_WIDTH-1:0] rd_data_q,  rd_data_d;

    // Address decode and write strobes
    logic [ADDR_WIDTH-1:0] rel_addr;
    logic                  in_bank;
    logic [2:0]            offset;
    logic                  wr_pulse;
    logic                  wr_hit;
    logic [7:0]            wdata;
    logic                  cmd_wr;
    logic                  cmd_arm;
    logic                  cmd_imm;
    logic                  cmd_abort;
    logic                  cmd_soft_rst;
    logic [7:0]            rd_byte;

    // An address below BASE_ADDR wraps to a large value in the subtraction.
    // It then fails the range test together with addresses above the bank.
    assign rel_addr = i_addr_bus - BASE_ADDR;
    assign in_bank  = (rel_addr < ADDR_WIDTH'(8));
    assign offset   = rel_addr[2:0];

    always_comb begin
        wr_en_d      = i_wr_enable_bus;
        wr_pulse     = i_wr_enable_bus & ~wr_en_q;
        wr_hit       = wr_pulse & in_bank;
        wdata        = i_data_write_bus[7:0];
        cmd_wr       = wr_hit && (offset == OFF_CMD);
        cmd_arm      = cmd_wr & wdata[CMD_ARM];
        cmd_imm      = cmd_wr & wdata[CMD_IMM];
        cmd_abort    = cmd_wr & wdata[CMD_ABORT];
        cmd_soft_rst = cmd_wr & wdata[CMD_SOFT_RST];
    end

    // Commit FSM next state. Among the CMD bits, ABORT wins over IMMEDIATE,
    // and IMMEDIATE wins over ARM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_abort) begin
                    state_d = ST_IDLE;
                end else if (cmd_imm) begin
                    state_d = ST_APPLY;
                end else if (cmd_arm) begin
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (cmd_abort) begin
                    state_d = ST_IDLE;
                end else if (cmd_imm || i_sync) begin
                    state_d = ST_APPLY;
                end
            end
            ST_APPLY: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Register writes and commit datapath
    always_comb begin
        ctrl_d     = ctrl_q;
        shadow_d   = shadow_q;
        div_d      = div_q;
        done_d     = done_q;
        update_d   = 1'b0;
        soft_rst_d = cmd_soft_rst;

        if (wr_hit) begin
            case (offset)
                OFF_CTRL: ctrl_d          = wdata;
                OFF_DIV0: shadow_d[7:0]   = wdata;
                OFF_DIV1: shadow_d[15:8]  = wdata;
                OFF_DIV2: shadow_d[23:16] = wdata;
                OFF_DIV3: shadow_d[31:24] = wdata;
                default: ;
            endcase
        end

        // Any CMD write clears done. A set in the same cycle (APPLY) wins.
        if (cmd_wr) begin
            done_d = 1'b0;
        end

        // APPLY takes shadow_q, the value registered before this edge. A shadow
        // write landing on the same edge applies to the next commit only.
        if (state_q == ST_APPLY) begin
            div_d    = shadow_q;
            update_d = 1'b1;
            done_d   = 1'b1;
        end
    end

    // Registered read-back from pre-write register contents
    always_comb begin
        rd_byte = 8'h00;
        if (in_bank) begin
            case (offset)
                OFF_ID:     rd_byte = ID_VALUE;
                OFF_CTRL:   rd_byte = ctrl_q;
                OFF_DIV0:   rd_byte = shadow_q[7:0];
                OFF_DIV1:   rd_byte = shadow_q[15:8];
                OFF_DIV2:   rd_byte = shadow_q[23:16];
                OFF_DIV3:   rd_byte = shadow_q[31:24];
                OFF_CMD:    rd_byte = 8'h00;
                OFF_STATUS: rd_byte = {6'b0, done_q, (state_q == ST_ARMED)};
                default:    rd_byte = 8'h00;
            endcase
        end
        rd_data_d      = '0;
        rd_data_d[7:0] = rd_byte;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q    <= ST_IDLE;
            wr_en_q    <= 1'b0;
            ctrl_q     <= 8'h00;
            shadow_q   <= DIV_RESET;
            div_q      <= DIV_RESET;
            done_q     <= 1'b0;
            update_q   <= 1'b0;
            soft_rst_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            wr_en_q    <= wr_en_d;
            ctrl_q     <= ctrl_d;
            shadow_q   <= shadow_d;
            div_q      <= div_d;
            done_q     <= done_d;
            update_q   <= update_d;
            soft_rst_q <= soft_rst_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign o_enable        = ctrl_q[0];
    assign o_div           = div_q;
    assign o_update        = update_q;
    assign o_soft_rst      = soft_rst_q;
    assign o_armed         = (state_q == ST_ARMED);
    assign o_data_read_bus = rd_data_q;

endmodule

// File: tb/tb_clk_ctrl_regs.sv
// ----------------------------------------------------------------------------
// Testbench for clk_ctrl_regs. Directed scenarios plus a randomized sequence,
// checked against a register-level model of the bank.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_clk_ctrl_regs;

    localparam int          AW   = 7;
    localparam int          DW   = 8;
    localparam logic [6:0]  BASE = 7'h20;
    localparam logic [7:0]  ID   = 8'hC5;
    localparam logic [31:0] DRST = 32'd1;

    // ---------------- clock / reset / DUT ----------------
    logic          i_clk;
    logic          i_rst;
    logic [AW-1:0] i_addr_bus;
    logic [DW-1:0] i_data_write_bus;
    logic          i_wr_enable_bus;
    logic [DW-1:0] o_data_read_bus;
    logic          i_sync;
    logic          o_enable;
    logic [31:0]   o_div;
    logic          o_update;
    logic          o_soft_rst;
    logic          o_armed;

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    clk_ctrl_regs #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .BASE_ADDR  (BASE),
        .ID_VALUE   (ID),
        .DIV_RESET  (DRST)
    ) dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .i_addr_bus       (i_addr_bus),
        .i_data_write_bus (i_data_write_bus),
        .i_wr_enable_bus  (i_wr_enable_bus),
        .o_data_read_bus  (o_data_read_bus),
        .i_sync           (i_sync),
        .o_enable         (o_enable),
        .o_div            (o_div),
        .o_update         (o_update),
        .o_soft_rst       (o_soft_rst),
        .o_armed          (o_armed)
    );

    int n_checks = 0;
    int n_fails  = 0;

    // Pulse counters, sampled 2 ns after each rising edge
    int upd_cnt  = 0;
    int srst_cnt = 0;
    always @(posedge i_clk) begin
        #2;
        if (o_update === 1'b1)   upd_cnt++;
        if (o_soft_rst === 1'b1) srst_cnt++;
    end

    // ---------------- reference model ----------------
    logic [7:0]  m_ctrl;
    logic [31:0] m_shadow;
    logic [31:0] m_div;
    bit          m_armed;
    bit          m_done;
    int          m_upd  = 0;
    int          m_srst = 0;
    logic [7:0]  exp_q[$];

    function automatic int off_of(input logic [6:0] a);
        int off;
        off = int'(a) - int'(BASE);
        if (off < 0 || off > 7) off = -1;
        return off;
    endfunction

    task automatic model_reset();
        m_ctrl   = 8'h00;
        m_shadow = DRST;
        m_div    = DRST;
        m_armed  = 0;
        m_done   = 0;
    endtask

    task automatic model_apply();
        m_div   = m_shadow;
        m_armed = 0;
        m_done  = 1;
        m_upd++;
    endtask

    task automatic model_write(input logic [6:0] a, input logic [7:0] d);
        int off;
        off = off_of(a);
        if (off == 1) m_ctrl = d;
        else if (off >= 2 && off <= 5) m_shadow[8*(off-2) +: 8] = d;
        else if (off == 6) begin
            if (d[3]) m_srst++;
            m_done = 0;
            if (d[2])      m_armed = 0;
            else if (d[1]) model_apply();
            else if (d[0]) m_armed = 1;
        end
    endtask

    task automatic model_sync();
        if (m_armed) model_apply();
    endtask

    function automatic logic [7:0] model_read(input logic [6:0] a);
        int off;
        logic [7:0] r;
        off = off_of(a);
        case (off)
            0:       r = ID;
            1:       r = m_ctrl;
            2:       r = m_shadow[7:0];
            3:       r = m_shadow[15:8];
            4:       r = m_shadow[23:16];
            5:       r = m_shadow[31:24];
            7:       r = {6'b0, m_done, m_armed};
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    // ---------------- driver tasks (entered and left at a falling edge) ----
    task automatic bus_write(input logic [6:0] a, input logic [7:0] d);
        i_addr_bus       = a;
        i_data_write_bus = d;
        i_wr_enable_bus  = 1'b1;
        @(posedge i_clk); @(negedge i_clk);
        i_wr_enable_bus  = 1'b0;
        @(posedge i_clk); @(negedge i_clk);
    endtask

    task automatic bus_read(input logic [6:0] a, output logic [7:0] d);
        i_addr_bus = a;
        @(posedge i_clk); @(negedge i_clk);
        d = o_data_read_bus;
    endtask

    task automatic pulse_sync();
        i_sync = 1'b1;
        @(posedge i_clk); @(negedge i_clk);
        i_sync = 1'b0;
        @(posedge i_clk); @(negedge i_clk);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge i_clk); @(negedge i_clk); end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [7:0] r;
        logic [6:0] offs [3];
        logic [7:0] exps [3];
        i_rst = 1'b0; i_addr_bus = '0; i_data_write_bus = '0;
        i_wr_enable_bus = 1'b0; i_sync = 1'b0;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        n_checks++; if (o_div !== DRST) begin n_fails++; $display("FAIL reset_div: got %h want %h", o_div, DRST); end
        n_checks++; if (o_update !== 1'b0) begin n_fails++; $display("FAIL reset_update: got %b want 0", o_update); end
        n_checks++; if (o_soft_rst !== 1'b0) begin n_fails++; $display("FAIL reset_soft_rst: got %b want 0", o_soft_rst); end
        n_checks++; if (o_enable !== 1'b0) begin n_fails++; $display("FAIL reset_enable: got %b want 0", o_enable); end
        n_checks++; if (o_armed !== 1'b0) begin n_fails++; $display("FAIL reset_armed: got %b want 0", o_armed); end
        n_checks++; if (o_data_read_bus !== 8'h00) begin n_fails++; $display("FAIL reset_rdata: got %h want 00", o_data_read_bus); end
        i_rst = 1'b1;
        model_reset();
        offs[0] = BASE;      exps[0] = 8'hC5;
        offs[1] = BASE + 1;  exps[1] = 8'h00;
        offs[2] = BASE + 7;  exps[2] = 8'h00;
        for (int i = 0; i < 3; i++) begin
            bus_read(offs[i], r);
            n_checks++;
            if (r !== exps[i]) begin n_fails++; $display("FAIL reset_read off%0d: got %h want %h", i, r, exps[i]); end
        end
        idle(3);
        n_checks++; if (upd_cnt !== 0) begin n_fails++; $display("FAIL reset_no_update: got %0d pulses want 0", upd_cnt); end
    endtask

    task automatic test_immediate();
        logic [7:0] r;
        logic [7:0] bytes_in [4];
        bytes_in[0] = 8'h78; bytes_in[1] = 8'h56; bytes_in[2] = 8'h34; bytes_in[3] = 8'h12;
        for (int i = 0; i < 4; i++) begin
            bus_write(BASE + 7'(2 + i), bytes_in[i]);
            model_write(BASE + 7'(2 + i), bytes_in[i]);
        end
        n_checks++; if (o_div !== DRST) begin n_fails++; $display("FAIL imm_shadow_only: got %h want %h", o_div, DRST); end
        i_addr_bus = BASE + 6; i_data_write_bus = 8'h02; i_wr_enable_bus = 1'b1;
        @(posedge i_clk); @(negedge i_clk);
        i_wr_enable_bus = 1'b0;
        n_checks++; if (o_update !== 1'b0 || o_div !== DRST) begin n_fails++; $display("FAIL imm_early: got upd=%b div=%h want upd=0 div=%h", o_update, o_div, DRST); end
        @(posedge i_clk); @(negedge i_clk);
        n_checks++; if (o_update !== 1'b1 || o_div !== 32'h12345678) begin n_fails++; $display("FAIL imm_apply: got upd=%b div=%h want upd=1 div=12345678", o_update, o_div); end
        @(posedge i_clk); @(negedge i_clk);
        n_checks++; if (o_update !== 1'b0) begin n_fails++; $display("FAIL imm_pulse_width: got upd=%b want 0", o_update); end
        model_write(BASE + 6, 8'h02);
        bus_read(BASE + 7, r);
        n_checks++; if (r !== 8'h02) begin n_fails++; $display("FAIL imm_status: got %h want 02", r); end
        n_checks++; if (upd_cnt !== m_upd) begin n_fails++; $display("FAIL imm_upd_count: got %0d want %0d", upd_cnt, m_upd); end
    endtask

    task automatic test_sync_commit();
        logic [7:0] r;
        bus_write(BASE + 2, 8'hFF); model_write(BASE + 2, 8'hFF);
        bus_write(BASE + 3, 8'h00); model_write(BASE + 3, 8'h00);
        bus_write(BASE + 4, 8'h00); model_write(BASE + 4, 8'h00);
        bus_write(BASE + 5, 8'h00); model_write(BASE + 5, 8'h00);
        bus_write(BASE + 6, 8'h01); model_write(BASE + 6, 8'h01);
        for (int i = 0; i < 20; i++) begin
            n_checks++;
            if (o_armed !== 1'b1 || o_div !== m_div) begin
                n_fails++; $display("FAIL sync_wait cyc%0d: got armed=%b div=%h want armed=1 div=%h", i, o_armed, o_div, m_div);
            end
            idle(1);
        end
        i_sync = 1'b1;
        @(posedge i_clk); @(negedge i_clk);
        i_sync = 1'b0;
        n_checks++; if (o_update !== 1'b0 || o_armed !== 1'b0) begin n_fails++; $display("FAIL sync_apply_state: got upd=%b armed=%b want 0 0", o_update, o_armed); end
        @(posedge i_clk); @(negedge i_clk);
        model_sync();
        n_checks++; if (o_div !== 32'h000000FF || o_update !== 1'b1) begin n_fails++; $display("FAIL sync_load: got div=%h upd=%b want 000000ff 1", o_div, o_update); end
        bus_read(BASE + 7, r);
        n_checks++; if (r !== 8'h02) begin n_fails++; $display("FAIL sync_status: got %h want 02", r); end
    endtask

    task automatic test_abort();
        logic [7:0] r;
        bus_write(BASE + 2, 8'h3C); model_write(BASE + 2, 8'h3C);
        bus_write(BASE + 6, 8'h01); model_write(BASE + 6, 8'h01);
        n_checks++; if (o_armed !== 1'b1) begin n_fails++; $display("FAIL abort_armed: got %b want 1", o_armed); end
        bus_write(BASE + 6, 8'h05); model_write(BASE + 6, 8'h05);
        n_checks++; if (o_armed !== 1'b0) begin n_fails++; $display("FAIL abort_idle: got %b want 0", o_armed); end
        pulse_sync(); model_sync();
        idle(2);
        n_checks++; if (upd_cnt !== m_upd) begin n_fails++; $display("FAIL abort_no_update: got %0d want %0d", upd_cnt, m_upd); end
        n_checks++; if (o_div !== m_div) begin n_fails++; $display("FAIL abort_div: got %h want %h", o_div, m_div); end
        bus_read(BASE + 7, r);
        n_checks++; if (r !== model_read(BASE + 7)) begin n_fails++; $display("FAIL abort_status: got %h want %h", r, model_read(BASE + 7)); end
    endtask

    task automatic test_write_hold_soft_rst();
        logic [7:0] r;
        int s0;
        // Data changes after the first edge: a repeated write would show up in CTRL.
        i_addr_bus = BASE + 1; i_data_write_bus = 8'h01; i_wr_enable_bus = 1'b1;
        @(posedge i_clk); @(negedge i_clk);
        i_data_write_bus = 8'hAA;
        idle(9);
        i_wr_enable_bus = 1'b0;
        idle(1);
        model_write(BASE + 1, 8'h01);
        n_checks++; if (o_enable !== 1'b1) begin n_fails++; $display("FAIL hold_enable: got %b want 1", o_enable); end
        bus_read(BASE + 1, r);
        n_checks++; if (r !== 8'h01) begin n_fails++; $display("FAIL hold_ctrl: got %h want 01", r); end
        s0 = srst_cnt;
        i_addr_bus = BASE + 6; i_data_write_bus = 8'h08; i_wr_enable_bus = 1'b1;
        @(posedge i_clk); @(negedge i_clk);
        n_checks++; if (o_soft_rst !== 1'b1) begin n_fails++; $display("FAIL soft_rst_high: got %b want 1", o_soft_rst); end
        @(posedge i_clk); @(negedge i_clk);
        n_checks++; if (o_soft_rst !== 1'b0) begin n_fails++; $display("FAIL soft_rst_width: got %b want 0", o_soft_rst); end
        idle(2);
        i_wr_enable_bus = 1'b0;
        idle(1);
        model_write(BASE + 6, 8'h08);
        n_checks++; if (srst_cnt !== s0 + 1) begin n_fails++; $display("FAIL soft_rst_count: got %0d want %0d", srst_cnt - s0, 1); end
        bus_read(BASE + 1, r);
        n_checks++; if (r !== 8'h01) begin n_fails++; $display("FAIL soft_rst_ctrl: got %h want 01", r); end
    endtask

    task automatic test_same_edge_read();
        logic [7:0] old_v;
        logic [7:0] r;
        old_v = model_read(BASE + 1);
        i_addr_bus = BASE + 1; i_data_write_bus = 8'h5A; i_wr_enable_bus = 1'b1;
        @(posedge i_clk); @(negedge i_clk);
        i_wr_enable_bus = 1'b0;
        model_write(BASE + 1, 8'h5A);
        n_checks++; if (o_data_read_bus !== old_v) begin n_fails++; $display("FAIL same_edge_read: got %h want %h", o_data_read_bus, old_v); end
        bus_read(BASE + 1, r);
        n_checks++; if (r !== 8'h5A) begin n_fails++; $display("FAIL after_write_read: got %h want 5a", r); end
    endtask

    task automatic test_reset_while_armed();
        bus_write(BASE + 3, 8'hA5); model_write(BASE + 3, 8'hA5);
        bus_write(BASE + 6, 8'h01); model_write(BASE + 6, 8'h01);
        n_checks++; if (o_armed !== 1'b1) begin n_fails++; $display("FAIL rst_armed_pre: got %b want 1", o_armed); end
        i_rst = 1'b0;
        @(posedge i_clk); @(negedge i_clk);
        i_rst = 1'b1;
        model_reset();
        pulse_sync(); model_sync();
        idle(2);
        n_checks++; if (upd_cnt !== m_upd) begin n_fails++; $display("FAIL rst_armed_update: got %0d want %0d", upd_cnt, m_upd); end
        n_checks++; if (o_armed !== 1'b0) begin n_fails++; $display("FAIL rst_armed_state: got %b want 0", o_armed); end
        n_checks++; if (o_div !== DRST) begin n_fails++; $display("FAIL rst_armed_div: got %h want %h", o_div, DRST); end
        n_checks++; if (o_enable !== 1'b0) begin n_fails++; $display("FAIL rst_armed_enable: got %b want 0", o_enable); end
    endtask

    task automatic test_random();
        logic [6:0] a;
        logic [7:0] d;
        logic [7:0] r;
        logic [7:0] e;
        int op;
        for (int i = 0; i < 250; i++) begin
            op = $urandom_range(0, 9);
            if ($urandom_range(0, 9) < 8) a = BASE + 7'($urandom_range(0, 7));
            else                          a = 7'($urandom_range(0, 127));
            if (op <= 4) begin
                d = 8'($urandom_range(0, 255));
                bus_write(a, d); model_write(a, d);
            end else if (op <= 6) begin
                pulse_sync(); model_sync();
            end else begin
                exp_q.push_back(model_read(a));
                bus_read(a, r);
                e = exp_q.pop_front();
                n_checks++;
                if (r !== e) begin n_fails++; $display("FAIL rand_read %0d addr %h: got %h want %h", i, a, r, e); end
            end
            n_checks++;
            if (o_div !== m_div || o_enable !== m_ctrl[0] || o_armed !== m_armed) begin
                n_fails++;
                $display("FAIL rand_state %0d: got div=%h en=%b armed=%b want div=%h en=%b armed=%b",
                         i, o_div, o_enable, o_armed, m_div, m_ctrl[0], m_armed);
            end
            n_checks++;
            if (upd_cnt !== m_upd || srst_cnt !== m_srst) begin
                n_fails++;
                $display("FAIL rand_pulses %0d: got upd=%0d srst=%0d want upd=%0d srst=%0d",
                         i, upd_cnt, srst_cnt, m_upd, m_srst);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_immediate();
        test_sync_commit();
        test_abort();
        test_write_hold_soft_rst();
        test_same_edge_read();
        test_reset_while_armed();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #2_000_000;
        n_checks++;
        n_fails++;
        $display("FAIL watchdog: got timeout want completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
